// File: rtl/scan_mux_seq_pkg.sv
// ============================================================================
// scan_mux_pkg : shared mode and state encodings for scan_mux_seq
// Rev 1.0
// ============================================================================
`default_nettype none

package scan_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_SCAN  = 1'b1;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/scan_mux_seq_if.sv
// ============================================================================
// scan_mux_seq_if : channel inputs and valid/ready output stage of the mux
// Rev 1.0
// ============================================================================
`default_nettype none

interface scan_mux_seq_if #(
  parameter int NUM_CH = 16,
  parameter int DATA_W = 8,
  parameter int SEL_W  = $clog2(NUM_CH)
);

  logic                     mode;
  logic [SEL_W-1:0]         sel_in;
  logic [NUM_CH-1:0]        ch_en;
  logic [NUM_CH*DATA_W-1:0] inp;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W-1:0]        out_data;
  logic [SEL_W-1:0]         out_ch;
  logic                     frame_done;

  // Source/consumer side
  modport master (
    output mode, sel_in, ch_en, inp, out_ready,
    input  out_valid, out_data, out_ch, frame_done
  );

  // Mux side
  modport slave (
    input  mode, sel_in, ch_en, inp, out_ready,
    output out_valid, out_data, out_ch, frame_done
  );

endinterface

`default_nettype wire

// File: rtl/scan_mux_seq_rr_next_ch.sv
// ============================================================================
// rr_next_ch : combinational round-robin picker, first set mask bit after last
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_next_ch #(
  parameter int NUM_CH = 16
) (
  input  logic [NUM_CH-1:0]         mask,
  input  logic [$clog2(NUM_CH)-1:0] last,
  output logic [$clog2(NUM_CH)-1:0] next,
  output logic                      found
);

  localparam int SEL_W = $clog2(NUM_CH);

  int               idx;
  logic [SEL_W-1:0] idx_s;

  // Walk from the farthest offset to the nearest so the nearest hit wins;
  // offset NUM_CH lands on last itself, making it the final choice.
  always_comb begin
    next  = '0;
    found = 1'b0;
    idx   = 0;
    idx_s = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = int'(last) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      idx_s = SEL_W'(idx);
      if (mask[idx_s]) begin
        next  = idx_s;
        found = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/scan_mux_seq.sv
// ============================================================================
// scan_mux_seq : registered N:1 channel mux, fixed or round-robin scan select
// Rev 1.0
// ============================================================================
`default_nettype none

module scan_mux_seq
  import scan_mux_pkg::*;
#(
  parameter int NUM_CH = 16,
  parameter int DATA_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  scan_mux_seq_if.slave bus
);

  localparam int               SEL_W    = $clog2(NUM_CH);
  localparam int               PAD_W    = 1 << SEL_W;
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_CH - 1);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] data_q, data_nxt;
  logic [SEL_W-1:0]  ch_q, ch_nxt;
  logic [SEL_W-1:0]  last_ch, last_nxt;
  logic              fresh, fresh_nxt;
  logic              fd_q, fd_nxt;

  logic [DATA_W-1:0] ch_data [NUM_CH];
  logic [PAD_W-1:0]  en_pad;
  logic [SEL_W-1:0]  rr_ch;
  logic              rr_found;
  logic [SEL_W-1:0]  cand_ch;
  logic              cand_ok;
  logic              slot_open;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign ch_data[i] = bus.inp[i*DATA_W +: DATA_W];
  end

  // Zero-padded enable mask: out-of-range fixed selects read a 0 bit
  assign en_pad = PAD_W'(bus.ch_en);

  rr_next_ch #(
    .NUM_CH (NUM_CH)
  ) u_rr (
    .mask  (bus.ch_en),
    .last  (last_ch),
    .next  (rr_ch),
    .found (rr_found)
  );

  assign cand_ch   = (bus.mode == MODE_SCAN) ? rr_ch    : bus.sel_in;
  assign cand_ok   = (bus.mode == MODE_SCAN) ? rr_found : en_pad[bus.sel_in];
  assign slot_open = (state == ST_EMPTY) || bus.out_ready;

  always_comb begin
    state_nxt = state;
    data_nxt  = data_q;
    ch_nxt    = ch_q;
    last_nxt  = last_ch;
    fresh_nxt = fresh;
    fd_nxt    = 1'b0;
    if (slot_open) begin
      if (cand_ok) begin
        state_nxt = ST_FULL;
        data_nxt  = ch_data[cand_ch];
        ch_nxt    = cand_ch;
        last_nxt  = cand_ch;
        fresh_nxt = 1'b0;
        // Right after reset the pointer is parked, so only a pick of the top
        // channel itself counts as a wrap.
        fd_nxt    = (bus.mode == MODE_SCAN) &&
                    (fresh ? (cand_ch == LAST_IDX) : (cand_ch <= last_ch));
      end else begin
        state_nxt = ST_EMPTY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_EMPTY;
      data_q  <= '0;
      ch_q    <= '0;
      last_ch <= LAST_IDX;
      fresh   <= 1'b1;
      fd_q    <= 1'b0;
    end else begin
      state   <= state_nxt;
      data_q  <= data_nxt;
      ch_q    <= ch_nxt;
      last_ch <= last_nxt;
      fresh   <= fresh_nxt;
      fd_q    <= fd_nxt;
    end
  end

  assign bus.out_valid  = (state == ST_FULL);
  assign bus.out_data   = data_q;
  assign bus.out_ch     = ch_q;
  assign bus.frame_done = fd_q;

endmodule

`default_nettype wire
